uart_pkt_parser: RTL and testbench
==================================

UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, the number of idle clock cycles between bytes that aborts a partial packet (used only with the Configuration macro).
REQ-002 Parameter MIN_LEN, default 4, the header length in bytes; the packet length field counts the header bytes as well as the payload.
REQ-003 clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 s_axis_tdata  input  8  received byte from uart_rx.
REQ-006 s_axis_tvalid  input  1  received byte is valid.
REQ-007 s_axis_tready  output  1  parser accepts the byte.
REQ-008 m_axis_tdata  output  8  payload byte.
REQ-009 m_axis_tvalid  output  1  payload byte is valid.
REQ-010 m_axis_tready  input  1  downstream accepts the payload byte.
REQ-011 m_axis_tlast  output  1  marks the final payload byte of the packet.
REQ-012 hdr_valid_o  output  1  one-cycle pulse: header decoded and accepted.
REQ-013 opcode_o  output  8  opcode of the current packet; held until the next header.
REQ-014 paylen_o  output  16  payload length (packet length minus MIN_LEN); held until the next header.
REQ-015 err_o  output  1  one-cycle pulse on a protocol error.

Function
REQ-016 A byte transfers on s_axis_tvalid && s_axis_tready; a payload byte transfers on m_axis_tvalid && m_axis_tready.
REQ-017 Header format, in byte order: opcode, reserved (value ignored), length LSB, length MSB.
REQ-018 FSM states: IDLE, RSVD, LEN_LO, LEN_HI, PAYLOAD, DROP.
- IDLE->RSVD on the opcode byte.
- RSVD->LEN_LO on the reserved byte.
- LEN_LO->LEN_HI on the length LSB.
- LEN_HI exits on the length MSB.
REQ-019 In IDLE, RSVD, LEN_LO, LEN_HI and DROP, s_axis_tready is 1.
REQ-020 In PAYLOAD, s_axis_tready = !m_axis_tvalid || m_axis_tready (one-entry output register, full throughput).
REQ-021 Supported opcodes: 0xEC echo, 0x10 add, 0x11 mul, 0x12 div.
REQ-022 On the LEN_HI byte, when len < MIN_LEN: pulse err_o and go to IDLE.
REQ-023 On the LEN_HI byte, when the opcode is unsupported: pulse err_o and go to DROP if len > MIN_LEN, otherwise to IDLE.
REQ-024 Otherwise, on the LEN_HI byte:
- pulse hdr_valid_o in the next cycle;
- load opcode_o and paylen_o;
- go to PAYLOAD if paylen > 0, otherwise to IDLE.
REQ-025 A 16-bit down-counter loaded with paylen decrements on each accepted input byte in PAYLOAD and DROP; the FSM returns to IDLE when the counter reaches 1 and a byte is accepted.
REQ-026 Each payload byte appears on m_axis_tdata one cycle after its input handshake.
REQ-027 m_axis_tlast is 1 exactly on the paylen-th payload byte.
REQ-028 m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid && !m_axis_tready.
REQ-029 In DROP, no m_axis_tvalid is produced.
REQ-030 A header byte may be accepted in the same cycle that the last output byte is still pending.
REQ-031 Length 0xFFFF gives paylen 65531 with no wrap; the counter never underflows.

Reset
REQ-032 While reset_i is high the state is IDLE and all outputs are 0: s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, hdr_valid_o, opcode_o, paylen_o, err_o.
REQ-033 s_axis_tready returns to 1 in the first cycle after reset is released.
REQ-034 A reset during a packet discards the partial packet and the output register; no err_o pulse is produced.

Configuration
REQ-035 With UART_PKT_TIMEOUT_EN defined, an idle-cycle counter runs in all states except IDLE.
- It clears on every accepted input byte.
- On reaching TIMEOUT_CYCLES it pulses err_o, drops any pending output byte, and returns to IDLE.
REQ-036 Without UART_PKT_TIMEOUT_EN, no timeout counter exists and a partial packet waits indefinitely.

Structure
REQ-037 Package uart_alu_pkg holds:
- opcode localparams (OP_ECHO=8'hEC, OP_ADD=8'h10, OP_MUL=8'h11, OP_DIV=8'h12);
- HDR_LEN=4;
- the FSM state enum typedef.
REQ-038 The timeout counter is the one natural sub-module, uart_pkt_timer, instantiated only under UART_PKT_TIMEOUT_EN.

Verification
REQ-039 Input EC 00 08 00 11 22 33 44 with m_axis_tready=1: hdr_valid_o pulses once, opcode_o=0xEC, paylen_o=4, output is 11 22 33 44, tlast on 44.
REQ-040 Same packet with m_axis_tready low for 5 cycles on byte 22: output is held stable, s_axis_tready=0 while the register is full, and no byte is lost.
REQ-041 Input 10 00 03 00, then EC 00 04 00: first packet gives err_o pulse and no hdr_valid_o; second gives hdr_valid_o with paylen_o=0 and no m_axis_tvalid.
REQ-042 Input 55 00 06 00 AA BB, then EC 00 05 00 7F: err_o pulses once, AA BB are dropped, output is only 7F with tlast.
REQ-043 reset_i asserted after byte 11 of the REQ-039 packet, then the full packet is resent: outputs are 0 during reset and the resent packet completes correctly.
REQ-044 With UART_PKT_TIMEOUT_EN and TIMEOUT_CYCLES=50, input EC 00 followed by 50 idle cycles: err_o pulses and the FSM returns to IDLE; a following valid packet parses correctly.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: opcodes, header length and FSM state encoding shared by the
// UART packet parser and its optional inactivity timer.
package uart_alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'h10;
    localparam logic [7:0] OP_MUL  = 8'h11;
    localparam logic [7:0] OP_DIV  = 8'h12;

    // Header bytes: opcode, reserved, length LSB, length MSB.
    localparam int HDR_LEN = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RSVD    = 3'd1,
        LEN_LO  = 3'd2,
        LEN_HI  = 3'd3,
        PAYLOAD = 3'd4,
        DROP    = 3'd5
    } state_t;

    // True for the opcodes the downstream ALU understands.
    function automatic logic is_supported_op(input logic [7:0] op);
        logic ok_s;
        case (op)
            OP_ECHO, OP_ADD, OP_MUL, OP_DIV: ok_s = 1'b1;
            default:                         ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

endpackage

// File: rtl/uart_pkt_timer.sv
// uart_pkt_timer: counts consecutive cycles without an accepted input byte
// while a packet is open; flags expiry after TIMEOUT_CYCLES such cycles.
// Only instantiated when UART_PKT_TIMEOUT_EN is defined.
module uart_pkt_timer
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic active,
    input  logic kick,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] count_r;

    // Expiry is decoded from the registered count, restarting on any byte.
    assign expired = active && (count_r == LIMIT);

    // Idle-cycle counter: cleared outside a packet, on a byte, or on expiry.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else if (!active || kick || expired) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + ONE;
        end
    end

endmodule

// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: splits a UART byte stream into 4-byte headers
// (opcode, reserved, len LSB, len MSB) and forwards payload bytes through a
// one-entry output register. Unsupported opcodes have their payload dropped.
// Optional feature: define UART_PKT_TIMEOUT_EN to abort stalled packets
// after TIMEOUT_CYCLES idle cycles.
module uart_pkt_parser
    import uart_alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MIN_LEN        = HDR_LEN
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        hdr_valid_o,
    output logic [7:0]  opcode_o,
    output logic [15:0] paylen_o,
    output logic        err_o
);

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

    state_t      state_r;
    logic        rdy_en_r;
    logic [7:0]  hdr_op_r;
    logic [7:0]  len_lo_r;
    logic [15:0] cnt_r;

    logic        out_free_s;
    logic        in_hs_s;
    logic        op_ok_s;
    logic        timeout_s;
    logic [15:0] len_s;
    logic [15:0] paylen_s;

    // Input ready: always open outside PAYLOAD; in PAYLOAD only when the output register can take a byte.
    always_comb begin
        out_free_s = !m_axis_tvalid || m_axis_tready;
        if (!rdy_en_r) begin
            s_axis_tready = 1'b0;
        end else if (state_r == PAYLOAD) begin
            s_axis_tready = out_free_s;
        end else begin
            s_axis_tready = 1'b1;
        end
    end

    // Header decode of the byte currently on the input.
    always_comb begin
        in_hs_s  = s_axis_tvalid && s_axis_tready;
        len_s    = {s_axis_tdata, len_lo_r};
        paylen_s = len_s - MIN_LEN_W;
        op_ok_s  = is_supported_op(hdr_op_r);
    end

`ifdef UART_PKT_TIMEOUT_EN
    uart_pkt_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .active  (state_r != IDLE),
        .kick    (in_hs_s),
        .expired (timeout_s)
    );
`else
    // Timeout disabled: a partial packet waits indefinitely; parameter kept for a uniform interface.
    logic [31:0] unused_timeout_cycles_s;
    assign unused_timeout_cycles_s = TIMEOUT_CYCLES;
    assign timeout_s               = 1'b0;
`endif

    // Packet FSM with registered payload output and status pulses.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= IDLE;
            rdy_en_r      <= 1'b0;
            hdr_op_r      <= 8'h00;
            len_lo_r      <= 8'h00;
            cnt_r         <= 16'h0000;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            hdr_valid_o   <= 1'b0;
            opcode_o      <= 8'h00;
            paylen_o      <= 16'h0000;
            err_o         <= 1'b0;
        end else begin
            rdy_en_r    <= 1'b1;
            hdr_valid_o <= 1'b0;
            err_o       <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (timeout_s) begin
                state_r       <= IDLE;
                err_o         <= 1'b1;
                m_axis_tvalid <= 1'b0;
            end else if (in_hs_s) begin
                case (state_r)
                    IDLE: begin
                        hdr_op_r <= s_axis_tdata;
                        state_r  <= RSVD;
                    end
                    RSVD: begin
                        state_r <= LEN_LO;
                    end
                    LEN_LO: begin
                        len_lo_r <= s_axis_tdata;
                        state_r  <= LEN_HI;
                    end
                    LEN_HI: begin
                        if (len_s < MIN_LEN_W) begin
                            err_o   <= 1'b1;
                            state_r <= IDLE;
                        end else if (!op_ok_s) begin
                            err_o <= 1'b1;
                            cnt_r <= paylen_s;
                            state_r <= (paylen_s != 16'h0000) ? DROP : IDLE;
                        end else begin
                            hdr_valid_o <= 1'b1;
                            opcode_o    <= hdr_op_r;
                            paylen_o    <= paylen_s;
                            cnt_r       <= paylen_s;
                            state_r     <= (paylen_s != 16'h0000) ? PAYLOAD : IDLE;
                        end
                    end
                    PAYLOAD: begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (cnt_r == 16'h0001);
                        cnt_r         <= cnt_r - 16'h0001;
                        if (cnt_r == 16'h0001) begin
                            state_r <= IDLE;
                        end
                    end
                    DROP: begin
                        cnt_r <= cnt_r - 16'h0001;
                        if (cnt_r == 16'h0001) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Self-checking bench for uart_pkt_parser: directed packets plus randomized
// packet streams compared against a packet-level reference model.
`timescale 1ns/1ps
module tb_uart_pkt_parser;

    localparam int TO_CYCLES = 50;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        hdr_valid_o;
    logic [7:0]  opcode_o;
    logic [15:0] paylen_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    uart_pkt_parser #(
        .TIMEOUT_CYCLES(TO_CYCLES),
        .MIN_LEN(4)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .hdr_valid_o   (hdr_valid_o),
        .opcode_o      (opcode_o),
        .paylen_o      (paylen_o),
        .err_o         (err_o)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  stim_q[$];
    logic [8:0]  obs_out_q[$];
    logic [8:0]  exp_out_q[$];
    logic [23:0] obs_hdr_q[$];
    logic [23:0] exp_hdr_q[$];
    int          obs_err, exp_err, obs_mvalid;
    int          hold_viol, ready_viol, stall_seen, stall_ready_hi;
    logic [7:0]  stall_byte = 8'h00;
    int          stall_left = 0;
    bit          stream_ok;

    // Reference model: walk the sent byte stream packet by packet.
    task automatic build_expect();
        int i;
        int len;
        logic [7:0] op;
        i = 0;
        exp_out_q.delete();
        exp_hdr_q.delete();
        exp_err = 0;
        while (i + 4 <= stim_q.size()) begin
            op  = stim_q[i];
            len = int'({stim_q[i+3], stim_q[i+2]});
            i   = i + 4;
            if (len < 4) begin
                exp_err++;
            end else if (!(op inside {8'hEC, 8'h10, 8'h11, 8'h12})) begin
                exp_err++;
                i = i + len - 4;
            end else begin
                exp_hdr_q.push_back({op, 16'(len - 4)});
                for (int k = 0; k < len - 4; k++) begin
                    exp_out_q.push_back({(k == len - 5), stim_q[i + k]});
                end
                i = i + len - 4;
            end
        end
    endtask

    task automatic clear_obs();
        obs_out_q.delete();
        obs_hdr_q.delete();
        obs_err = 0; obs_mvalid = 0; hold_viol = 0; ready_viol = 0;
        stall_seen = 0; stall_ready_hi = 0;
    endtask

    // Drive tx_q with optional gaps/stalls and record everything the DUT emits.
    task automatic run_stream(input int gap_pct, input int stall_pct, input int drain, input int budget);
        int   cyc;
        int   quiet;
        bit   fresh;
        bit   forced;
        logic prev_hold;
        logic [8:0] prev_out;
        cyc = 0; quiet = 0; fresh = 1'b1; prev_hold = 1'b0; prev_out = 9'h000;
        stream_ok = 1'b1;
        while (quiet < drain) begin
            @(negedge clk_i);
            if (tx_q.size() != 0) begin
                if (fresh) s_axis_tvalid = ($urandom_range(99) >= gap_pct);
                if (s_axis_tvalid) fresh = 1'b0;
                s_axis_tdata = tx_q[0];
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = 8'h00;
            end
            forced = (stall_left > 0) && m_axis_tvalid && (m_axis_tdata == stall_byte);
            if (forced) begin
                m_axis_tready = 1'b0;
                stall_left--;
                stall_seen++;
            end else begin
                m_axis_tready = ($urandom_range(99) >= stall_pct);
            end
            #1;
            if (prev_hold && (!m_axis_tvalid || ({m_axis_tlast, m_axis_tdata} != prev_out))) hold_viol++;
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_out  = {m_axis_tlast, m_axis_tdata};
            if (!s_axis_tready && !prev_hold) ready_viol++;
            if (forced && s_axis_tready) stall_ready_hi++;
            if (hdr_valid_o) obs_hdr_q.push_back({opcode_o, paylen_o});
            if (err_o) obs_err++;
            if (m_axis_tvalid) obs_mvalid++;
            if (m_axis_tvalid && m_axis_tready) obs_out_q.push_back({m_axis_tlast, m_axis_tdata});
            if (s_axis_tvalid && s_axis_tready) begin
                void'(tx_q.pop_front());
                fresh = 1'b1;
            end
            if (tx_q.size() == 0 && !m_axis_tvalid) quiet++;
            else quiet = 0;
            cyc++;
            if (cyc >= budget) begin
                stream_ok = 1'b0;
                quiet = drain;
            end
        end
        @(negedge clk_i);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, hdr_valid_o, opcode_o, paylen_o, err_o} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, hdr_valid_o, opcode_o, paylen_o, err_o});
        end
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_echo(input bit with_stall);
        logic [8:0] exp_b[4];
        exp_b = '{9'h011, 9'h022, 9'h033, 9'h144};
        clear_obs();
        if (with_stall) begin
            stall_byte = 8'h22;
            stall_left = 5;
        end
        tx_q = {8'hEC, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(0, 0, 4, 300);
        checks++;
        if (!stream_ok) begin errors++; $display("FAIL echo_budget stall=%0d stream did not drain", with_stall); end
        checks++;
        if (obs_hdr_q.size() != 1) begin errors++; $display("FAIL echo_hdr_count got %0d want 1", obs_hdr_q.size()); end
        else begin
            checks++;
            if (obs_hdr_q[0] !== {8'hEC, 16'd4}) begin errors++; $display("FAIL echo_hdr got %h want ec0004", obs_hdr_q[0]); end
        end
        checks++;
        if (obs_out_q.size() != 4) begin errors++; $display("FAIL echo_out_count got %0d want 4", obs_out_q.size()); end
        for (int i = 0; i < 4 && i < obs_out_q.size(); i++) begin
            checks++;
            if (obs_out_q[i] !== exp_b[i]) begin errors++; $display("FAIL echo_byte%0d got %h want %h", i, obs_out_q[i], exp_b[i]); end
        end
        checks++;
        if (obs_err != 0 || hold_viol != 0 || ready_viol != 0) begin
            errors++;
            $display("FAIL echo_flags err=%0d hold=%0d ready=%0d want 0 0 0", obs_err, hold_viol, ready_viol);
        end
        if (with_stall) begin
            checks++;
            if (stall_seen != 5 || stall_ready_hi != 0) begin
                errors++;
                $display("FAIL stall_hold stalls=%0d ready_hi=%0d want 5 0", stall_seen, stall_ready_hi);
            end
        end
        stall_left = 0;
    endtask

    task automatic test_short_then_zero();
        clear_obs();
        tx_q = {8'h10, 8'h00, 8'h03, 8'h00, 8'hEC, 8'h00, 8'h04, 8'h00};
        run_stream(0, 0, 4, 200);
        checks++;
        if (obs_err != 1) begin errors++; $display("FAIL short_err got %0d want 1", obs_err); end
        checks++;
        if (obs_hdr_q.size() != 1) begin errors++; $display("FAIL zero_hdr_count got %0d want 1", obs_hdr_q.size()); end
        else begin
            checks++;
            if (obs_hdr_q[0] !== {8'hEC, 16'd0}) begin errors++; $display("FAIL zero_hdr got %h want ec0000", obs_hdr_q[0]); end
        end
        checks++;
        if (obs_mvalid != 0) begin errors++; $display("FAIL zero_no_output got %0d valid cycles want 0", obs_mvalid); end
    endtask

    task automatic test_drop();
        clear_obs();
        tx_q = {8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h7F};
        run_stream(0, 0, 4, 200);
        checks++;
        if (obs_err != 1) begin errors++; $display("FAIL drop_err got %0d want 1", obs_err); end
        checks++;
        if (obs_out_q.size() != 1) begin errors++; $display("FAIL drop_out_count got %0d want 1", obs_out_q.size()); end
        else begin
            checks++;
            if (obs_out_q[0] !== 9'h17F) begin errors++; $display("FAIL drop_out got %h want 17f", obs_out_q[0]); end
        end
        checks++;
        if (obs_mvalid != 1) begin errors++; $display("FAIL drop_valid_cycles got %0d want 1", obs_mvalid); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp_b[4];
        exp_b = '{9'h011, 9'h022, 9'h033, 9'h144};
        clear_obs();
        tx_q = {8'hEC, 8'h00, 8'h08, 8'h00, 8'h11};
        run_stream(0, 100, 3, 100);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, hdr_valid_o, opcode_o, paylen_o, err_o} !== 37'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, hdr_valid_o, opcode_o, paylen_o, err_o});
        end
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        clear_obs();
        tx_q = {8'hEC, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(0, 0, 4, 300);
        checks++;
        if (obs_out_q.size() != 4 || obs_err != 0 || obs_hdr_q.size() != 1) begin
            errors++;
            $display("FAIL midreset_resend out=%0d err=%0d hdr=%0d want 4 0 1", obs_out_q.size(), obs_err, obs_hdr_q.size());
        end
        for (int i = 0; i < 4 && i < obs_out_q.size(); i++) begin
            checks++;
            if (obs_out_q[i] !== exp_b[i]) begin errors++; $display("FAIL midreset_byte%0d got %h want %h", i, obs_out_q[i], exp_b[i]); end
        end
    endtask

    task automatic test_max_len();
        clear_obs();
        tx_q = {8'hEC, 8'h00, 8'hFF, 8'hFF, 8'h5A};
        run_stream(0, 0, 4, 100);
        checks++;
        if (obs_hdr_q.size() != 1) begin errors++; $display("FAIL maxlen_hdr_count got %0d want 1", obs_hdr_q.size()); end
        else begin
            checks++;
            if (obs_hdr_q[0] !== {8'hEC, 16'd65531}) begin errors++; $display("FAIL maxlen_hdr got %h want ecfffb", obs_hdr_q[0]); end
        end
        checks++;
        if (obs_out_q.size() != 1 || obs_out_q[0] !== 9'h05A) begin
            errors++;
            $display("FAIL maxlen_first_byte count=%0d want 1 byte 05a (no tlast)", obs_out_q.size());
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic test_random(input int n_pkts, input int gap_pct, input int stall_pct);
        int len;
        logic [7:0] op;
        clear_obs();
        tx_q.delete();
        for (int p = 0; p < n_pkts; p++) begin
            case ($urandom_range(5))
                0:       op = 8'hEC;
                1:       op = 8'h10;
                2:       op = 8'h11;
                3:       op = 8'h12;
                default: op = 8'($urandom);
            endcase
            if ($urandom_range(7) == 0) len = int'($urandom_range(3));
            else len = 4 + int'($urandom_range(8));
            tx_q.push_back(op);
            tx_q.push_back(8'($urandom));
            tx_q.push_back(8'(len));
            tx_q.push_back(8'h00);
            for (int k = 0; k < len - 4; k++) tx_q.push_back(8'($urandom));
        end
        stim_q = tx_q;
        build_expect();
        run_stream(gap_pct, stall_pct, 6, 20000);
        checks++;
        if (!stream_ok) begin errors++; $display("FAIL rand_budget gap=%0d stall=%0d stream did not drain", gap_pct, stall_pct); end
        checks++;
        if (obs_err != exp_err) begin errors++; $display("FAIL rand_err got %0d want %0d", obs_err, exp_err); end
        checks++;
        if (obs_hdr_q.size() != exp_hdr_q.size()) begin errors++; $display("FAIL rand_hdr_count got %0d want %0d", obs_hdr_q.size(), exp_hdr_q.size()); end
        for (int i = 0; i < exp_hdr_q.size() && i < obs_hdr_q.size(); i++) begin
            checks++;
            if (obs_hdr_q[i] !== exp_hdr_q[i]) begin errors++; $display("FAIL rand_hdr%0d got %h want %h", i, obs_hdr_q[i], exp_hdr_q[i]); end
        end
        checks++;
        if (obs_out_q.size() != exp_out_q.size()) begin errors++; $display("FAIL rand_out_count got %0d want %0d", obs_out_q.size(), exp_out_q.size()); end
        for (int i = 0; i < exp_out_q.size() && i < obs_out_q.size(); i++) begin
            checks++;
            if (obs_out_q[i] !== exp_out_q[i]) begin errors++; $display("FAIL rand_out%0d got %h want %h", i, obs_out_q[i], exp_out_q[i]); end
        end
        checks++;
        if (hold_viol != 0 || ready_viol != 0) begin
            errors++;
            $display("FAIL rand_handshake hold=%0d ready=%0d want 0 0", hold_viol, ready_viol);
        end
    endtask

`ifdef UART_PKT_TIMEOUT_EN
    task automatic test_timeout();
        clear_obs();
        tx_q = {8'hEC, 8'h00};
        run_stream(0, 0, TO_CYCLES + 20, 500);
        checks++;
        if (obs_err != 1 || obs_hdr_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_err err=%0d hdr=%0d want 1 0", obs_err, obs_hdr_q.size());
        end
        clear_obs();
        tx_q = {8'hEC, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
        run_stream(0, 0, 4, 200);
        checks++;
        if (obs_out_q.size() != 2 || obs_err != 0 || obs_hdr_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_recover out=%0d err=%0d hdr=%0d want 2 0 1", obs_out_q.size(), obs_err, obs_hdr_q.size());
        end else begin
            checks++;
            if ({obs_out_q[0], obs_out_q[1]} !== {9'h011, 9'h122}) begin
                errors++;
                $display("FAIL timeout_recover_bytes got %h %h want 011 122", obs_out_q[0], obs_out_q[1]);
            end
        end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_echo(1'b0);
        test_echo(1'b1);
        test_short_then_zero();
        test_drop();
        test_reset_mid();
        test_max_len();
        test_random(40, 30, 30);
        test_random(25, 0, 0);
`ifdef UART_PKT_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
